// File: rtl/rand_pkg.sv
// rand_pkg: shared LFSR constants and FSM state encoding for the random arbiter
package rand_pkg;
    localparam int LFSR_W = 10;
    localparam int TAP_HI = 10;
    localparam int TAP_LO = 7;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 10'b1;
    typedef enum logic {FILL = 1'b0, READY = 1'b1} state_t;
endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: combinational one-step advance of the 10-bit Fibonacci LFSR
module lfsr_step
    import rand_pkg::*;
(
    input  logic [LFSR_W-1:0] i_lfsr,
    output logic [LFSR_W-1:0] o_lfsr
);
    // tap numbers are 1-based in the polynomial, vector bits are 0-based
    always_comb o_lfsr = {i_lfsr[LFSR_W-2:0], i_lfsr[TAP_HI-1] ^ i_lfsr[TAP_LO-1]};
endmodule

// File: rtl/rand_arbiter.sv
// rand_arbiter: round-robin delivery of fresh LFSR bits to NREQ requesters
module rand_arbiter
    import rand_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = LFSR_W,
    parameter int OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             seed_we,
    input  logic [WIDTH-1:0] seed,
    output logic [NREQ-1:0]  ack,
    output logic [OUT_W-1:0] rdata,
    output logic             busy
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(OUT_W);

    state_t           r_state;
    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] w_lfsr_nxt;
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    w_gnt;
    logic [NREQ-1:0]  w_mask;
    logic [NREQ-1:0]  w_pool;
    logic [NREQ-1:0]  r_ack;
    logic [OUT_W-1:0] r_rdata;

    lfsr_step u_step (
        .i_lfsr (r_lfsr),
        .o_lfsr (w_lfsr_nxt)
    );

    // first requester at or above ptr, falling back to the lowest one when nothing sits above it
    always_comb begin
        w_mask = {NREQ{1'b1}} << r_ptr;
        w_pool = (|(req & w_mask)) ? (req & w_mask) : req;
        w_gnt  = '0;
        for (int i = NREQ - 1; i >= 0; i--) w_gnt = w_pool[i] ? PW'(i) : w_gnt;
    end

    // FILL shifts OUT_W times, READY grants once; a seed load restarts the fill from anywhere
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
            r_lfsr  <= LFSR_SEED;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_ack   <= '0;
            r_rdata <= '0;
        end else begin
            r_ack <= '0;
            if (seed_we) begin
                r_lfsr  <= (seed == '0) ? LFSR_SEED : seed;
                r_cnt   <= '0;
                r_state <= FILL;
            end else if (r_state == FILL) begin
                r_lfsr  <= w_lfsr_nxt;
                r_cnt   <= (r_cnt == CW'(OUT_W - 1)) ? '0 : r_cnt + 1'b1;
                r_state <= (r_cnt == CW'(OUT_W - 1)) ? READY : FILL;
            end else if (|req) begin
                r_ack   <= NREQ'(1) << w_gnt;
                r_rdata <= r_lfsr[OUT_W-1:0];
                r_ptr   <= (w_gnt == PW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;
                r_state <= FILL;
            end
        end
    end

    assign ack   = r_ack;
    assign rdata = r_rdata;
    assign busy  = (r_state == FILL);
endmodule

// File: tb/tb_rand_arbiter.sv
// tb_rand_arbiter: table-driven and scoreboard checks of grant order, timing and random data
module tb_rand_arbiter;
    localparam int NREQ  = 4;
    localparam int OUT_W = 4;

    typedef struct {
        logic [NREQ-1:0]  ack;
        logic [OUT_W-1:0] rdata;
        int               edge_n;
    } exp_t;

    typedef struct {
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] ack;
    } vec_t;

    logic             clk;
    logic             rst;
    logic [NREQ-1:0]  req;
    logic             seed_we;
    logic [9:0]       seed;
    logic [NREQ-1:0]  ack;
    logic [OUT_W-1:0] rdata;
    logic             busy;

    logic             rst_q = 1'b1;
    int               edge_n = 0;
    int               checks = 0;
    int               errors = 0;
    exp_t             q[$];
    exp_t             cur;
    logic [OUT_W-1:0] hold = '0;
    logic [9:0]       ref_lfsr;
    vec_t             vecs[15];
    logic [NREQ-1:0]  rr[5];

    rand_arbiter #(.NREQ(NREQ), .WIDTH(10), .OUT_W(OUT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .seed_we (seed_we),
        .seed    (seed),
        .ack     (ack),
        .rdata   (rdata),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rst_q  <= rst;
        edge_n <= rst ? 0 : edge_n + 1;
    end

    function automatic logic [9:0] ref_step4(input logic [9:0] x);
        logic [10:1] l;
        l = x;
        repeat (OUT_W) l = {l[9:1], l[10] ^ l[7]};
        return l;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic expect_grant(input logic [NREQ-1:0] a, input int at);
        q.push_back('{a, ref_lfsr[OUT_W-1:0], at});
        ref_lfsr = ref_step4(ref_lfsr);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait_ready_busy", 32'(busy), 32'(0));
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        req     = '0;
        seed_we = 1'b0;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        ref_lfsr = ref_step4(10'd1);
    endtask

    always @(negedge clk) begin
        if (rst_q) hold = '0;
        else if (ack != '0) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got %b want none (edge %0d)", ack, edge_n);
            end else begin
                cur = q.pop_front();
                check("ack", 32'(ack), 32'(cur.ack));
                check("rdata", 32'(rdata), 32'(cur.rdata));
                check("ack_edge", 32'(edge_n), 32'(cur.edge_n));
                hold = cur.rdata;
            end
        end else check("rdata_hold", 32'(rdata), 32'(hold));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs = '{
            '{4'b0001, 4'b0001}, '{4'b1111, 4'b0010}, '{4'b1111, 4'b0100},
            '{4'b1111, 4'b1000}, '{4'b1111, 4'b0001}, '{4'b0001, 4'b0001},
            '{4'b0100, 4'b0100}, '{4'b0101, 4'b0001}, '{4'b0101, 4'b0100},
            '{4'b1010, 4'b1000}, '{4'b1010, 4'b0010}, '{4'b0011, 4'b0001},
            '{4'b1001, 4'b1000}, '{4'b0110, 4'b0010}, '{4'b0110, 4'b0100}
        };
        rr = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        rst     = 1'b1;
        req     = '0;
        seed_we = 1'b0;
        seed    = '0;
        @(negedge clk);
        check("reset_ack", 32'(ack), 32'(0));
        check("reset_rdata", 32'(rdata), 32'(0));
        check("reset_busy", 32'(busy), 32'(1));
        // req held on port 0 from reset: grants on edges 5, 10, 15
        rst      = 1'b0;
        req      = 4'b0001;
        ref_lfsr = ref_step4(10'd1);
        for (int k = 0; k < 3; k++) expect_grant(4'b0001, 5 + 5 * k);
        repeat (4) @(negedge clk);
        check("busy_ready", 32'(busy), 32'(0));
        @(negedge clk);
        check("busy_fill", 32'(busy), 32'(1));
        repeat (10) @(negedge clk);
        req = '0;
        // all ports held: strict rotation, one grant every OUT_W+1 cycles
        wait_ready();
        for (int k = 0; k < 5; k++) expect_grant(rr[k], edge_n + 1 + 5 * k);
        req = 4'b1111;
        repeat (21) @(negedge clk);
        req = '0;
        // table of single grants from a fresh pointer
        do_reset();
        foreach (vecs[i]) begin
            wait_ready();
            req = vecs[i].req;
            expect_grant(vecs[i].ack, edge_n + 1);
            @(negedge clk);
            req = '0;
        end
        // zero seed with a request in READY: seed wins, grant deferred
        wait_ready();
        req      = 4'b0001;
        seed     = '0;
        seed_we  = 1'b1;
        ref_lfsr = ref_step4(10'd1);
        expect_grant(4'b0001, edge_n + 6);
        @(negedge clk);
        seed_we = 1'b0;
        repeat (5) @(negedge clk);
        // all-ones seed loaded mid-FILL restarts the fill
        req      = 4'b0010;
        seed     = 10'h3FF;
        seed_we  = 1'b1;
        ref_lfsr = ref_step4(10'h3FF);
        expect_grant(4'b0010, edge_n + 6);
        @(negedge clk);
        seed_we = 1'b0;
        repeat (5) @(negedge clk);
        req = '0;
        // reset during an ack cycle carrying nonzero data
        wait_ready();
        seed    = 10'h040;
        seed_we = 1'b1;
        @(negedge clk);
        seed_we  = 1'b0;
        ref_lfsr = ref_step4(10'h040);
        wait_ready();
        req = 4'b0100;
        expect_grant(4'b0100, edge_n + 1);
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        check("rst_ack", 32'(ack), 32'(0));
        check("rst_rdata", 32'(rdata), 32'(0));
        check("rst_busy", 32'(busy), 32'(1));
        rst      = 1'b0;
        req      = 4'b0100;
        ref_lfsr = ref_step4(10'd1);
        expect_grant(4'b0100, 5);
        repeat (5) @(negedge clk);
        req = '0;
        repeat (10) @(negedge clk);
        check("queue_empty", 32'(q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
